// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared definitions for the two-master SimpleBus arbiter.
// Contents:
//   bus_state_e  - arbiter FSM state (IDLE / GRANT / WAIT / RESP)
//   bus_owner_e  - which master owns the in-flight transaction
//   BUS_ERR_DATA - read data returned with a timeout error response
package ysyx_25070198_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } bus_owner_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ysyx_25070198_bus_arbiter.sv
// Two-master (IFU fetch, LSU data) to one-slave SimpleBus arbiter.
// One transaction is in flight at a time: the winning request is latched in
// IDLE, presented to the slave in GRANT, the response is awaited in WAIT and
// returned to the owning master as a one-cycle pulse in RESP. A slave that
// stalls for too long is turned into an error response.
//
// Handshake rules: a request transfers on a cycle where reqValid and reqReady
// are both 1; masters hold reqValid and their fields until then. reqReady is
// combinational and only ever 1 in IDLE, for the selected master. The slave
// accepts on mem_reqValid && mem_reqReady and later returns exactly one
// mem_respValid pulse, which is only honoured in WAIT.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   ifu_reqValid/raddr           fetch request in; ifu_reqReady accept out
//   ifu_respValid/rdata/err      fetch response out
//   lsu_reqValid/addr/wen/wdata/wmask  data request in; lsu_reqReady out
//   lsu_respValid/rdata/err      data response out
//   mem_reqValid/addr/wen/wdata/wmask  slave request out; mem_reqReady in
//   mem_respValid/rdata          slave response in
//   dbg_state_o                  current FSM state, for observation only
module ysyx_25070198_bus_arbiter
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  // IFU fetch port
  input  logic              ifu_reqValid,
  input  logic [ADDR_W-1:0] ifu_raddr,
  output logic              ifu_reqReady,
  output logic              ifu_respValid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  // LSU data port
  input  logic              lsu_reqValid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_reqReady,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  // Memory slave port
  output logic              mem_reqValid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_reqReady,
  input  logic              mem_respValid,
  input  logic [DATA_W-1:0] mem_rdata,
  // Debug
  output bus_state_e        dbg_state_o
);

  // Wide enough to hold TIMEOUT_CYCLES-2 without wrapping before it fires.
  localparam int          CNT_W     = $clog2(TIMEOUT_CYCLES + 2) + 1;
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  bus_state_e        state_q, state_d;
  bus_owner_e        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              mem_req_q, mem_req_d;

  logic              ifu_resp_q, ifu_resp_d;
  logic              lsu_resp_q, lsu_resp_d;
  logic              ifu_err_q, ifu_err_d;
  logic              lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration: fixed priority, LSU over IFU. Gated by rst so no master sees
  // an accept while the arbiter is held in reset.
  // ---------------------------------------------------------------------------
  logic lsu_grant, ifu_grant;

  assign lsu_grant = rst && (state_q == ST_IDLE) && lsu_reqValid;
  assign ifu_grant = rst && (state_q == ST_IDLE) && ifu_reqValid && !lsu_reqValid;

  // cnt_q counts completed GRANT/WAIT cycles since the accept. Firing when
  // cnt_q + 2 reaches the limit puts the error pulse exactly TIMEOUT_CYCLES
  // cycles after the accept cycle. A limit of 0 disables the check.
  logic [31:0] cnt_ext;
  logic        timeout_hit;

  assign cnt_ext     = {{(32-CNT_W){1'b0}}, cnt_q};
  assign timeout_hit = (TIMEOUT_U != 32'd0) && ((cnt_ext + 32'd2) >= TIMEOUT_U);

  // Response selection shared by the normal and timeout paths.
  logic              resp_go;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mem_req_d   = 1'b0;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    ifu_err_d   = 1'b0;
    lsu_err_d   = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (lsu_grant) begin
          owner_d   = OWN_LSU;
          addr_d    = lsu_addr;
          wen_d     = lsu_wen;
          wdata_d   = lsu_wdata;
          wmask_d   = lsu_wmask;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          state_d   = ST_GRANT;
        end else if (ifu_grant) begin
          // Fetches are always reads: no write enable, no byte lanes.
          owner_d   = OWN_IFU;
          addr_d    = ifu_raddr;
          wen_d     = 1'b0;
          wdata_d   = '0;
          wmask_d   = 4'h0;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          state_d   = ST_GRANT;
        end
      end

      ST_GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          resp_go   = 1'b1;
          resp_err  = 1'b1;
          resp_data = DATA_W'(BUS_ERR_DATA);
        end else if (mem_reqReady) begin
          state_d = ST_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real response beats a timeout landing on the same cycle.
        if (mem_respValid) begin
          resp_go   = 1'b1;
          resp_data = mem_rdata;
        end else if (timeout_hit) begin
          resp_go   = 1'b1;
          resp_err  = 1'b1;
          resp_data = DATA_W'(BUS_ERR_DATA);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only the owner's response registers change; the other master's rdata
    // keeps its last value and its valid/err stay low.
    if (resp_go) begin
      state_d = ST_RESP;
      if (owner_q == OWN_LSU) begin
        lsu_resp_d  = 1'b1;
        lsu_err_d   = resp_err;
        lsu_rdata_d = resp_data;
      end else begin
        ifu_resp_d  = 1'b1;
        ifu_err_d   = resp_err;
        ifu_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= 4'h0;
      mem_req_q   <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_req_q   <= mem_req_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_err_q   <= ifu_err_d;
      lsu_err_q   <= lsu_err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ifu_reqReady  = ifu_grant;
  assign lsu_reqReady  = lsu_grant;

  assign ifu_respValid = ifu_resp_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_err       = ifu_err_q;

  assign lsu_respValid = lsu_resp_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_err       = lsu_err_q;

  assign mem_reqValid  = mem_req_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ysyx_25070198_bus_arbiter.sv
// Directed bench for the two-master bus arbiter, built with an 8-cycle
// timeout. The initial block acts as both masters and the slave; a negedge
// monitor pops expected responses ({owner, err, rdata}) from exp_q whenever
// either master sees a response pulse.
module tb_ysyx_25070198_bus_arbiter;
  import ysyx_25070198_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_reqValid, ifu_reqReady, ifu_respValid, ifu_err;
  logic [AW-1:0] ifu_raddr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_reqValid, lsu_wen, lsu_reqReady, lsu_respValid, lsu_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wmask;
  logic          mem_reqValid, mem_wen, mem_reqReady, mem_respValid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;
  bus_state_e    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  ysyx_25070198_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_reqValid(ifu_reqValid), .ifu_raddr(ifu_raddr), .ifu_reqReady(ifu_reqReady),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_reqReady(lsu_reqReady),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_reqReady(mem_reqReady),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [33:0] obs;
    if (ifu_respValid || lsu_respValid) begin
      chk("resp_onehot", 64'(ifu_respValid & lsu_respValid), 64'd0);
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'({ifu_respValid, lsu_respValid}), 64'd0);
      end else begin
        obs = lsu_respValid ? {1'b1, lsu_err, lsu_rdata} : {1'b0, ifu_err, ifu_rdata};
        chk("sb_resp", 64'(obs), 64'(exp_q.pop_front()));
      end
    end
  end

  // One complete transaction from the IDLE cycle in which it is accepted up to
  // the IDLE cycle after its response. req_wait/resp_wait add slave stalls.
  task automatic txn(input string tag, input bit lsu, input logic [31:0] addr,
                     input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
                     input logic [31:0] rdata, input int req_wait, input int resp_wait);
    logic        e_wen;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    e_wen   = lsu & wen;
    e_mask  = lsu ? wmask : 4'h0;
    e_wdata = lsu ? wdata : 32'h0;
    if (lsu) begin
      lsu_reqValid = 1'b1; lsu_addr = addr; lsu_wen = wen;
      lsu_wdata = wdata; lsu_wmask = wmask;
    end else begin
      ifu_reqValid = 1'b1; ifu_raddr = addr;
    end
    #1;
    chk({tag, "_ready"}, 64'({ifu_reqReady, lsu_reqReady}), lsu ? 64'd1 : 64'd2);
    exp_q.push_back({lsu, 1'b0, rdata});
    step();
    if (lsu) lsu_reqValid = 1'b0; else ifu_reqValid = 1'b0;
    for (int i = 0; i <= req_wait; i++) begin
      #1;
      chk({tag, "_grant_st"}, 64'(dbg_state), 64'(ST_GRANT));
      chk({tag, "_mem_valid"}, 64'(mem_reqValid), 64'd1);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
      chk({tag, "_mem_wen"}, 64'(mem_wen), 64'(e_wen));
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
      chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'(e_mask));
      chk({tag, "_ready_busy"}, 64'({ifu_reqReady, lsu_reqReady}), 64'd0);
      mem_reqReady = (i == req_wait);
      step();
      mem_reqReady = 1'b0;
    end
    for (int i = 0; i <= resp_wait; i++) begin
      #1;
      chk({tag, "_wait_st"}, 64'(dbg_state), 64'(ST_WAIT));
      chk({tag, "_wait_memv"}, 64'(mem_reqValid), 64'd0);
      chk({tag, "_wait_resp"}, 64'({ifu_respValid, lsu_respValid}), 64'd0);
      mem_respValid = (i == resp_wait);
      mem_rdata     = (i == resp_wait) ? rdata : $urandom();
      step();
      mem_respValid = 1'b0;
    end
    #1;
    chk({tag, "_resp_v"}, 64'({ifu_respValid, lsu_respValid}), lsu ? 64'd1 : 64'd2);
    chk({tag, "_resp_err"}, 64'({ifu_err, lsu_err}), 64'd0);
    chk({tag, "_resp_data"}, 64'(lsu ? lsu_rdata : ifu_rdata), 64'(rdata));
    step();
    chk({tag, "_idle_st"}, 64'(dbg_state), 64'(ST_IDLE));
    chk({tag, "_pulse_end"}, 64'({ifu_respValid, lsu_respValid}), 64'd0);
    chk({tag, "_rdata_hold"}, 64'(lsu ? lsu_rdata : ifu_rdata), 64'(rdata));
  endtask

  initial begin
    rst = 1'b0;
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0000;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = 4'h0;
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = '0;

    // Reset state, with a request pending that must not be accepted.
    #3;
    chk("rst_ready", 64'({ifu_reqReady, lsu_reqReady}), 64'd0);
    chk("rst_resp", 64'({ifu_respValid, lsu_respValid, ifu_err, lsu_err}), 64'd0);
    chk("rst_mem", 64'({mem_reqValid, mem_wen, mem_wmask}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    step();
    ifu_reqValid = 1'b0;
    rst = 1'b1;
    step();

    // IFU-only read, zero-wait slave.
    txn("ifu_read", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 0, 0);

    // Simultaneous requests: LSU store wins, IFU follows in the next IDLE.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0004;
    txn("lsu_sw", 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 32'h0000_0000, 0, 0);
    txn("ifu_2nd", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 0, 0);

    // Slave stalls: 3 request-wait cycles and 2 response-wait cycles.
    txn("stall", 1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 3, 2);

    // LSU byte write with random data and a mid-size stall.
    txn("lsu_sb", 1'b1, 32'h8000_2003, 1'b1, $urandom(), 4'h8, $urandom(), 1, 1);

    // Timeout: slave never accepts; error pulse 8 cycles after the accept.
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    #1;
    chk("to_ready", 64'(lsu_reqReady), 64'd1);
    exp_q.push_back({1'b1, 1'b1, BUS_ERR_DATA});
    step();
    lsu_reqValid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk("to_pending", 64'({mem_reqValid, lsu_respValid}), 64'd2);
      step();
    end
    #1;
    chk("to_resp", 64'({lsu_respValid, lsu_err, ifu_respValid}), 64'd6);
    chk("to_data", 64'(lsu_rdata), 64'(BUS_ERR_DATA));
    chk("to_memv", 64'(mem_reqValid), 64'd0);
    step();
    chk("to_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("to_err_end", 64'(lsu_err), 64'd0);

    // Spurious slave responses in IDLE and GRANT are ignored.
    mem_respValid = 1'b1; mem_rdata = 32'hBAD0_0001;
    step();
    mem_respValid = 1'b0;
    chk("spur_idle_st", 64'(dbg_state), 64'(ST_IDLE));
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0100;
    #1;
    chk("spur_ready", 64'(ifu_reqReady), 64'd1);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0297});
    step();
    ifu_reqValid = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'hBAD0_0002;
    step();
    mem_respValid = 1'b0;
    chk("spur_grant_st", 64'(dbg_state), 64'(ST_GRANT));
    chk("spur_grant_resp", 64'({ifu_respValid, lsu_respValid}), 64'd0);
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0297;
    step();
    mem_respValid = 1'b0;
    chk("spur_resp", 64'({ifu_respValid, ifu_rdata}), 64'({1'b1, 32'h0000_0297}));
    step();

    // Reset during WAIT: outputs clear without a clock edge, no late pulse.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0200;
    step();
    ifu_reqValid = 1'b0;
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    chk("rw_wait_st", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b0;
    #1;
    chk("rw_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rw_mem", 64'({mem_reqValid, mem_wen, mem_wmask}), 64'd0);
    chk("rw_addr", 64'(mem_addr), 64'd0);
    chk("rw_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    chk("rw_resp", 64'({ifu_respValid, lsu_respValid, ifu_err, lsu_err}), 64'd0);
    mem_respValid = 1'b1; mem_rdata = 32'hBAD0_0003;
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rw_no_pulse", 64'({ifu_respValid, lsu_respValid}), 64'd0);
    end
    mem_respValid = 1'b0;
    chk("rw_idle_st", 64'(dbg_state), 64'(ST_IDLE));

    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25070198_bus_arbiter.md
# ysyx_25070198_bus_arbiter

Two-master, one-slave SimpleBus arbiter sitting directly downstream of the IFU fetch port and the LSU data port and in front of the single memory port (DPI memory model today, SRAM/AXI bridge later). It owns exactly one outstanding transaction at a time. It latches the winning request, drives it to the slave, routes the response back to the originating master, and converts a hung slave into an error response after a bounded timeout.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, maximum number of cycles in GRANT+WAIT before a forced error response; 0 disables the timeout
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `ifu_reqValid`  in  1  fetch request; held until `ifu_reqReady`
- `ifu_raddr`  in  ADDR_W  fetch address
- `ifu_reqReady`  out  1  fetch request accepted this cycle
- `ifu_respValid`  out  1  one-cycle fetch response pulse
- `ifu_rdata`  out  DATA_W  fetch data, valid with `ifu_respValid`
- `ifu_err`  out  1  fetch response is a timeout error
- `lsu_reqValid`, `lsu_addr`, `lsu_wen`, `lsu_wdata`, `lsu_wmask[3:0]`  in  data request fields
- `lsu_reqReady`, `lsu_respValid`, `lsu_rdata`, `lsu_err`  out  as the IFU equivalents
- `mem_reqValid`  out  1  slave request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask[3:0]`  out  latched request fields
- `mem_reqReady`  in  1  slave accepts the request
- `mem_respValid`  in  1  slave response pulse
- `mem_rdata`  in  DATA_W  slave read data

## Operation
- States:
  - IDLE: no transaction in flight.
  - GRANT: `mem_reqValid`=1 until `mem_reqReady`.
  - WAIT: waiting for `mem_respValid`.
  - RESP: one-cycle response pulse to the owning master.
- IDLE arbitration:
  - Fixed priority, LSU over IFU.
  - `x_reqReady` is combinational: 1 only in IDLE, and only for the selected master.
  - On accept, latch addr, wen, wdata, wmask and owner ID, then go to GRANT.
  - IFU requests are latched with wen=0 and wmask=0.
- GRANT: when `mem_reqReady`=1, go to WAIT. Request fields are stable throughout GRANT.
- WAIT: when `mem_respValid`=1, latch `mem_rdata` and go to RESP.
- RESP:
  - Assert the owner's `respValid` with the latched rdata.
  - The non-owner's outputs stay 0.
  - Next state is IDLE.
- Writes still complete through `mem_respValid`. The returned rdata is passed through unchanged.
- Timeout:
  - Counter clears on accept and increments each cycle in GRANT or WAIT.
  - At count == `TIMEOUT_CYCLES` (nonzero), go to RESP with `err`=1 and rdata=32'hDEAD_BEEF.
  - `mem_reqValid` drops immediately.
- `mem_respValid` outside WAIT is ignored. A slave responding after a timeout is a slave protocol violation, and the arbiter does not track it.
- A request deasserted by a master before its reqReady is simply never granted. No state is affected.

## Timing
- Reset values (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - All `*_reqReady`, `*_respValid`, `*_err`, and `mem_reqValid` are 0.
  - All data/address outputs are 0.
- Reset mid-transaction aborts the transaction with no response pulse.
- Zero-wait slave round trip:
  - Cycle 0: accept.
  - Cycle 1: `mem_reqValid`=1, `mem_reqReady`=1.
  - Cycle 2: `mem_respValid`.
  - Cycle 3: master `respValid`.
  - Cycle 4: earliest next accept.
- Each slave request-wait cycle or response-wait cycle adds exactly one cycle.
- Simultaneous IFU and LSU in IDLE: the LSU is granted. The IFU is granted at the next IDLE if it is still requesting.
- Response pulse width is exactly 1 cycle. `rdata` holds its value until the next RESP.

## Structure
- Shared package `ysyx_25070198_bus_pkg` holds:
  - the state enum (IDLE/GRANT/WAIT/RESP);
  - the owner ID enum (OWN_IFU/OWN_LSU);
  - the constant `BUS_ERR_DATA`=32'hDEAD_BEEF.
- The block is flat, with no sub-module. The timeout counter is inline.

## Test plan
- IFU-only read at 0x8000_0000, zero-wait slave returning 0x0010_0073 -> `ifu_respValid` at cycle 3 with rdata 0x0010_0073, err=0, and `lsu_respValid` stays 0.
- IFU and LSU request together in the same IDLE cycle (LSU sw to 0x8000_1000, data 0x1234_5678, mask 4'hF) -> LSU is granted first and `mem_wen`=1 with those fields. The IFU is granted at the next IDLE, with `mem_wen`=0.
- Slave holds `mem_reqReady` low 3 cycles, then responds after 2 more cycles -> `mem_addr` is stable throughout. The response arrives 5 cycles later than the zero-wait case.
- `TIMEOUT_CYCLES`=8 and the slave never responds -> exactly 8 cycles after accept, `lsu_respValid`=1 with err=1 and rdata 0xDEAD_BEEF. The state then returns to IDLE.
- `rst` asserted during WAIT -> all outputs are 0 immediately without a clock edge. No response pulse occurs after `rst` is released.
- Spurious `mem_respValid` in IDLE and GRANT -> no master `respValid` is asserted and the state is unchanged.
